seq_calc: RTL



---
 rtl/seq_calc_if.sv | 26 ++
 rtl/seq_calc.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_calc_if.sv
// rtl/seq_calc_if.sv - switch/button/LED bundle for seq_calc
interface seq_calc_if #(
   parameter int W = 4
);
   logic [2*W-1:0] sw;
   logic [3:0]     btn;
   logic [2*W-1:0] led;
   logic           busy;
   logic           err;

   modport master (
      output sw,
      output btn,
      input  led,
      input  busy,
      input  err
   );

   modport slave (
      input  sw,
      input  btn,
      output led,
      output busy,
      output err
   );
endinterface

// File: rtl/seq_calc.sv
// rtl/seq_calc.sv - clocked mini calculator: add/sub, sort, iterative multiply and divide
// Optional SEQ_CALC_BTN_SYNC_EN inserts a two-flop btn synchroniser before edge detection.
module seq_calc #(
   parameter int W = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   seq_calc_if.slave bus
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV
   } state_t;

   state_t         state, state_n;
   logic [3:0]     btn_s;
   logic [3:0]     btn_q;
   logic [3:0]     start;
   logic [W-1:0]   a_r, a_n;
   logic [W-1:0]   b_r, b_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [2*W-1:0] acc, acc_n;
   logic [W-1:0]   rem, rem_n;
   logic [W-1:0]   quo, quo_n;
   logic [2*W-1:0] led_r, led_n;
   logic           err_r, err_n;

   logic [W-1:0]   sw_a, sw_b;
   logic [W-1:0]   sum, dif;
   logic [2*W-1:0] acc_step;
   logic [W:0]     trial;
   logic           ge;
   logic [W-1:0]   dif_div;
   logic [W-1:0]   rem_step;
   logic [W-1:0]   quo_step;

`ifdef SEQ_CALC_BTN_SYNC_EN
   logic [3:0] sync1, sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.btn;
         sync2 <= sync1;
      end
   end

   assign btn_s = sync2;
`else
   assign btn_s = bus.btn;
`endif

   assign start = btn_s & ~btn_q;

   assign sw_a = bus.sw[2*W-1:W];
   assign sw_b = bus.sw[W-1:0];
   assign sum  = sw_a + sw_b;
   assign dif  = sw_a - sw_b;

   // One shift-add step: add a shifted by the current bit position when that b bit is set.
   assign acc_step = acc + (b_r[cnt] ? ({{W{1'b0}}, a_r} << cnt) : {2*W{1'b0}});

   // Restoring divide: quo doubles as the dividend shift register, its LSBs fill with quotient bits.
   assign trial    = {rem, quo[W-1]};
   assign ge       = (trial >= {1'b0, b_r});
   assign dif_div  = trial[W-1:0] - b_r;
   assign rem_step = ge ? dif_div : trial[W-1:0];
   assign quo_step = {quo[W-2:0], ge};

   always_comb begin
      state_n = state;
      a_n     = a_r;
      b_n     = b_r;
      cnt_n   = cnt;
      acc_n   = acc;
      rem_n   = rem;
      quo_n   = quo;
      led_n   = led_r;
      err_n   = err_r;
      case (state)
         S_IDLE: begin
            if (start[0]) begin
               a_n   = sw_a;
               b_n   = sw_b;
               err_n = 1'b0;
               led_n = {sum, dif};
            end else if (start[1]) begin
               a_n   = sw_a;
               b_n   = sw_b;
               err_n = 1'b0;
               led_n = (sw_b < sw_a) ? {sw_b, sw_a} : {sw_a, sw_b};
            end else if (start[2]) begin
               a_n     = sw_a;
               b_n     = sw_b;
               err_n   = 1'b0;
               acc_n   = '0;
               cnt_n   = '0;
               state_n = S_MUL;
            end else if (start[3]) begin
               a_n   = sw_a;
               b_n   = sw_b;
               err_n = 1'b0;
               if (sw_b == '0) begin
                  led_n = {{W{1'b1}}, sw_a};
                  err_n = 1'b1;
               end else begin
                  rem_n   = '0;
                  quo_n   = sw_a;
                  cnt_n   = '0;
                  state_n = S_DIV;
               end
            end
         end
         S_MUL: begin
            acc_n = acc_step;
            if (cnt == CNT_LAST) begin
               led_n   = acc_step;
               cnt_n   = '0;
               state_n = S_IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_DIV: begin
            rem_n = rem_step;
            quo_n = quo_step;
            if (cnt == CNT_LAST) begin
               led_n   = {quo_step, rem_step};
               cnt_n   = '0;
               state_n = S_IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         btn_q <= '0;
         a_r   <= '0;
         b_r   <= '0;
         cnt   <= '0;
         acc   <= '0;
         rem   <= '0;
         quo   <= '0;
         led_r <= '0;
         err_r <= 1'b0;
      end else begin
         state <= state_n;
         btn_q <= btn_s;
         a_r   <= a_n;
         b_r   <= b_n;
         cnt   <= cnt_n;
         acc   <= acc_n;
         rem   <= rem_n;
         quo   <= quo_n;
         led_r <= led_n;
         err_r <= err_n;
      end
   end

   assign bus.led  = led_r;
   assign bus.busy = (state != S_IDLE);
   assign bus.err  = err_r;
endmodule
